// File: rtl/mult_arb_pkg.sv
// Shared types, widths and the round-robin select helper for the
// multiplier arbiter slice.
package mult_arb_pkg;

   localparam int NREQ_DEF = 4;   // default number of requesters
   localparam int NREQ_MAX = 4;   // grant_id is 2 bits wide, so at most 4
   localparam int GRANT_W  = 2;
   localparam int OP_W     = 8;
   localparam int PROD_W   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Returns the first valid index found searching upward from ptr,
   // wrapping at n. Returns 0 when nothing is valid; callers gate on
   // |valid themselves.
   function automatic logic [GRANT_W-1:0] rr_select(
      input logic [NREQ_MAX-1:0] valid,
      input logic [GRANT_W-1:0]  ptr,
      input int                  n
   );
      logic [GRANT_W-1:0] sel;
      int                 idx;
      sel = '0;
      // Walk from the farthest candidate back to ptr so the closest
      // valid requester is the last one written and therefore wins.
      for (int k = NREQ_MAX - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (valid[idx[GRANT_W-1:0]]) sel = idx[GRANT_W-1:0];
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/serial_multiplier.sv
// Shared 8x8 unsigned multiplier with a registered 16-bit product and
// one cycle of latency. The product only updates while en is high so it
// holds the last result between operations.
module serial_multiplier
   import mult_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] product
);

   // Register the full-width product when enabled.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) product <= '0;
      else if (en) product <= PROD_W'(a) * PROD_W'(b);
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to one shared
// 8x8 multiplier. One operation is in flight at a time:
// IDLE (accept) -> MUL (multiply) -> RESP (hold until consumed).
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [OP_W*NREQ-1:0] req_a,
   input  logic [OP_W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [PROD_W-1:0]    rsp_data,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic                 busy,
   output logic [GRANT_W-1:0]   grant_id
);

   state_t                state;
   logic [GRANT_W-1:0]    ptr;
   logic [GRANT_W-1:0]    winner;
   logic [NREQ-1:0]       winner_oh;
   logic [NREQ_MAX-1:0]   valid_ext;
   logic                  any_valid;
   logic [OP_W-1:0]       op_a;
   logic [OP_W-1:0]       op_b;
   logic [OP_W-1:0]       next_a;
   logic [OP_W-1:0]       next_b;
   logic [PROD_W-1:0]     product;

   // Pick this cycle's round-robin winner and steer its operands.
   // NOTE: every signal gets a default first so no latch is inferred.
   always_comb begin
      valid_ext             = '0;
      valid_ext[NREQ-1:0]   = req_valid;
      any_valid             = |req_valid;
      winner                = rr_select(valid_ext, ptr, NREQ);
      winner_oh             = '0;
      next_a                = '0;
      next_b                = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == GRANT_W'(i)) begin
            winner_oh[i] = 1'b1;
            next_a       = req_a[i*OP_W +: OP_W];
            next_b       = req_b[i*OP_W +: OP_W];
         end
      end
   end

   // Accept strobe is combinational and only offered while idle; it is
   // forced low while reset is held so the reset state is fully quiet.
   assign req_ready = (rst && state == IDLE && any_valid) ? winner_oh : '0;
   assign busy      = (state != IDLE);
   assign rsp_data  = product;

   // Control FSM: grant, operand capture, response hand-off, pointer update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         grant_id  <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_valid <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_id <= winner;
                  op_a     <= next_a;
                  op_b     <= next_b;
                  state    <= MUL;
               end
            end
            MUL: begin
               rsp_valid <= NREQ'(1) << grant_id;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready[grant_id]) begin
                  rsp_valid <= '0;
                  ptr       <= (grant_id == GRANT_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

   serial_multiplier u_mul (
      .clk     (clk),
      .rst     (rst),
      .en      (state == MUL),
      .a       (op_a),
      .b       (op_b),
      .product (product)
   );

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: reset state, single operations,
// product corner cases, response back-pressure, reset abort, round-robin
// order and fairness.
module tb_mult_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic [3:0]  rsp_ready;
   logic        busy;
   logic [1:0]  grant_id;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;

   mult_arbiter #(.NREQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 2 time units after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
      cyc_cnt++;
   endtask

   // One complete isolated operation on a single port.
   task automatic do_op(input int port, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
      logic [3:0] oh;
      oh = 4'b0001 << port;
      req_valid = oh;
      req_a[port*8 +: 8] = a;
      req_b[port*8 +: 8] = b;
      #1 check("op_accept", req_ready, oh);
      cyc();
      req_valid = '0;
      check("op_mul_busy", busy, 1);
      check("op_mul_ready", req_ready, 0);
      check("op_mul_rsp", rsp_valid, 0);
      cyc();
      check("op_rsp_valid", rsp_valid, oh);
      check("op_rsp_data", rsp_data, exp);
      check("op_grant", grant_id, port);
      rsp_ready = 4'hF;
      cyc();
      rsp_ready = '0;
      check("op_done_busy", busy, 0);
      check("op_done_rsp", rsp_valid, 0);
      check("op_hold_data", rsp_data, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int last;
      rst       = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '0;

      // Reset state
      #3;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      cyc();
      rst = 1'b1;

      // Basic op, accepted in first cycle after release
      do_op(0, 8'd13, 8'd11, 16'd143);

      // Product corners
      do_op(1, 8'd255, 8'd255, 16'hFE01);
      do_op(2, 8'd0, 8'd200, 16'd0);
      do_op(3, 8'd1, 8'd255, 16'd255);

      // Withdrawn request: valid drops before the edge, nothing starts
      req_valid = 4'b0100;
      #1 check("drop_ready", req_ready, 4'b0100);
      req_valid = '0;
      cyc();
      check("drop_busy", busy, 0);
      cyc();
      check("drop_no_rsp", rsp_valid, 0);

      // Back-pressure: rsp_ready[0] low for 5 cycles, others high (ignored)
      req_valid = 4'b0001;
      req_a[7:0] = 8'd12;
      req_b[7:0] = 8'd12;
      cyc();
      req_valid = 4'b1110;
      cyc();
      rsp_ready = 4'b1110;
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", rsp_valid, 4'b0001);
         check("bp_rsp_data", rsp_data, 16'd144);
         check("bp_req_ready", req_ready, 0);
         check("bp_busy", busy, 1);
         cyc();
      end
      req_valid = '0;
      rsp_ready = 4'b0001;
      cyc();
      rsp_ready = '0;
      check("bp_release_busy", busy, 0);
      check("bp_release_rsp", rsp_valid, 0);

      // Reset during MUL aborts the operation
      req_valid = 4'b0010;
      req_a[15:8] = 8'd9;
      req_b[15:8] = 8'd9;
      cyc();
      req_valid = '0;
      check("abort_in_mul", busy, 1);
      #1 rst = 1'b0;
      #1;
      check("abort_req_ready", req_ready, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_rsp_data", rsp_data, 0);
      check("abort_busy", busy, 0);
      check("abort_grant", grant_id, 0);
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("abort_no_rsp", rsp_valid, 0);
         check("abort_idle", busy, 0);
      end
      do_op(2, 8'd3, 8'd7, 16'd21);

      // Round robin from reset with all four valid
      rst = 1'b0;
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_a[i*8 +: 8] = 8'(i + 1);
         req_b[i*8 +: 8] = 8'd10;
      end
      req_valid = 4'hF;
      rsp_ready = 4'hF;
      last = 0;
      for (int k = 0; k < 5; k++) begin
         int g;
         g = k % 4;
         #1 check("rr_ready", req_ready, 4'b0001 << g);
         if (k > 0) check("rr_interval", cyc_cnt - last, 3);
         last = cyc_cnt;
         cyc();
         cyc();
         check("rr_rsp_valid", rsp_valid, 4'b0001 << g);
         check("rr_rsp_data", rsp_data, (g + 1) * 10);
         check("rr_grant", grant_id, g);
         cyc();
      end

      // Fairness: port 1 held valid, port 3 joins, wins next
      req_valid = 4'b0010;
      req_a[15:8] = 8'd2;
      req_b[15:8] = 8'd2;
      #1 check("fair_p1_ready", req_ready, 4'b0010);
      cyc();
      cyc();
      check("fair_p1_data", rsp_data, 16'd4);
      req_valid = 4'b1010;
      req_a[31:24] = 8'd5;
      req_b[31:24] = 8'd5;
      #1 check("fair_resp_ready", req_ready, 0);
      cyc();
      #1 check("fair_p3_ready", req_ready, 4'b1000);
      cyc();
      cyc();
      check("fair_p3_rsp", rsp_valid, 4'b1000);
      check("fair_p3_data", rsp_data, 16'd25);
      check("fair_p3_grant", grant_id, 3);
      req_valid = '0;
      cyc();
      check("fair_end_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters sharing one 8x8 multiplier.
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  NREQ  per-requester operation request.
REQ-005 SHALL have port: req_a  input  8*NREQ  multiplicand, requester i in bits [8i+7:8i].
REQ-006 SHALL have port: req_b  input  8*NREQ  multiplier, same packing as req_a.
REQ-007 SHALL have port: req_ready  output  NREQ  one-hot accept strobe.
REQ-008 SHALL have port: rsp_valid  output  NREQ  one-hot result-valid to owning requester.
REQ-009 SHALL have port: rsp_data  output  16  unsigned product, shared by all requesters.
REQ-010 SHALL have port: rsp_ready  input  NREQ  per-requester result accept.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: grant_id  output  2  index of current/last granted requester.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, RESP; exactly one operation in flight.
REQ-014 IDLE: if any req_valid, SHALL select winner g by round-robin starting at ptr, assert req_ready[g] combinationally in that cycle only, capture req_a/req_b slice g into operand registers, load grant_id=g, go MUL; else stay IDLE, req_ready all zero.
REQ-015 Round-robin: ptr SHALL be the search start index; after a completed response ptr <= (g+1) mod NREQ.
REQ-016 MUL: operand registers SHALL drive the shared multiplier; multiplier registers the product at the end of this cycle; next state RESP unconditionally.
REQ-017 RESP: rsp_valid[g]=1, rsp_data=registered product; both SHALL stay stable until rsp_ready[g]=1 at a rising edge, then go IDLE.
REQ-018 Latency SHALL be exactly 2 cycles from the accept edge to first rsp_valid; minimum issue interval 3 cycles.
REQ-019 req_ready SHALL be zero in MUL and RESP; new requests are not accepted while busy.
REQ-020 rsp_ready bits other than g SHALL be ignored; rsp_valid bits other than g SHALL be zero.
REQ-021 A requester SHALL be allowed to drop req_valid before acceptance; no operation results.
REQ-022 Product SHALL be full-width unsigned 8x8->16, no truncation (255*255=16'hFE01).
REQ-023 rsp_data SHALL be don't-care-but-stable (holds last product) when no rsp_valid.

Reset
REQ-024 On rst low, SHALL go IDLE immediately: req_ready=0, rsp_valid=0, rsp_data=0, busy=0, grant_id=0, ptr=0, operand registers=0.
REQ-025 Reset mid-operation (MUL or RESP) SHALL abort it with no response after release.
REQ-026 The multiplier sub-module SHALL share rst; first acceptance possible in first cycle after release.

Structure
REQ-027 Package mult_arb_pkg SHALL hold NREQ default, OP_W=8, PROD_W=16, the state enum, and the round-robin select function.
REQ-028 SHALL instantiate exactly one serial_multiplier (8x8, registered 16-bit output, 1-cycle latency) as the shared datapath.
REQ-029 Arbitration, FSM and response registers SHALL live in mult_arbiter itself.

Verification
REQ-030 Port 0 valid a=13,b=11 -> req_ready[0] same cycle, rsp_valid[0] 2 cycles later, rsp_data=143.
REQ-031 All four valid from reset, rsp_ready tied high -> grants 0,1,2,3,0 in order, each 3 cycles apart.
REQ-032 Operands 255*255 -> 16'hFE01; 0*200 -> 0; 1*255 -> 255.
REQ-033 rsp_ready[g] low 5 cycles -> rsp_valid/rsp_data stable, all req_ready low, busy high throughout.
REQ-034 rst low during MUL -> all outputs 0 asynchronously, no rsp_valid after release; then port 2 request a=3,b=7 -> rsp_data=21 on rsp_valid[2].
REQ-035 Port 1 continuously valid, port 3 raises valid -> port 3 granted after at most one further port-1 operation.
